ula_rr_scheduler: RTL and testbench

//  Shares one sequential_basic_ula between N_REQ requesters.
//  - Picks requesters round-robin and issues one op at a time to the ULA.
//  - Detects completion through the ULA valid pulse; bounds the wait with a timeout.
//  - Returns result, carry and requester ID over a valid/ready response channel.

---
 rtl/ula_rr_scheduler.sv | 167 ++++++++++++++++
 tb/tb_ula_rr_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_rr_scheduler.sv
// Round-robin scheduler sharing one sequential ULA between N_REQ requesters.
// One op in flight at a time; completion is the ULA valid pulse, bounded by a
// timeout; results go back over a registered valid/ready response channel.
module ula_rr_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [4*N_REQ-1:0]       req_op,
  input  logic [16*N_REQ-1:0]      req_a,
  input  logic [16*N_REQ-1:0]      req_b,
  output logic [4:0]               ula_op_selector,
  output logic [15:0]              ula_data_a,
  output logic [15:0]              ula_data_b,
  input  logic                     ula_data_valid,
  input  logic [31:0]              ula_data_result,
  input  logic                     ula_data_carryout,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [31:0]              rsp_result,
  output logic                     rsp_carry,
  output logic                     rsp_err,
  output logic                     rsp_timeout
);

  localparam int unsigned IdW      = $clog2(N_REQ);
  localparam logic [4:0]  OpUnused = 5'd0;
  localparam logic [7:0]  CntLast  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e           state_q;
  logic [IdW-1:0]   ptr_q;
  logic [7:0]       cnt_q;
  logic [15:0]      a_q, b_q;
  logic [IdW-1:0]   id_q;
  logic [4:0]       ula_op_q;
  logic             rsp_valid_q;
  logic [31:0]      result_q;
  logic             carry_q;
  logic             err_q;
  logic             timeout_q;

  logic             win_found;
  logic [IdW-1:0]   win_idx;
  int unsigned      cand;
  logic [3:0]       sel_op;
  logic [15:0]      sel_a, sel_b;
  logic             sel_illegal;

  // Winner: first pending request searching upward from ptr_q+1, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = (32'(ptr_q) + k) % N_REQ;
      if (!win_found && req_valid[IdW'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IdW'(cand);
      end
    end
  end

  // Slot mux for the winner's op/operands and the legality check.
  always_comb begin
    sel_op      = req_op[win_idx*4 +: 4];
    sel_a       = req_a[win_idx*16 +: 16];
    sel_b       = req_b[win_idx*16 +: 16];
    sel_illegal = (sel_op == 4'd0) || (sel_op > 4'd8);
  end

  // Grant is only offered in IDLE and is held off while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && win_found && !rst) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Control FSM; every output it drives is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= IdW'(N_REQ - 1);
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      ula_op_q    <= OpUnused;
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= win_idx;
            ptr_q <= win_idx;
            if (sel_illegal) begin
              // Illegal op never reaches the ULA.
              result_q    <= '0;
              carry_q     <= 1'b0;
              err_q       <= 1'b1;
              timeout_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else begin
              ula_op_q <= {1'b0, sel_op};
              state_q  <= StIssue;
            end
          end
        end
        StIssue: begin
          // Dropping the op after one cycle turns the sticky ULA valid into a pulse.
          ula_op_q <= OpUnused;
          cnt_q    <= '0;
          state_q  <= StWait;
        end
        StWait: begin
          if (ula_data_valid) begin
            result_q    <= ula_data_result;
            carry_q     <= ula_data_carryout;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else if (cnt_q == CntLast) begin
            result_q    <= '0;
            carry_q     <= 1'b0;
            timeout_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ula_op_selector = ula_op_q;
  assign ula_data_a      = a_q;
  assign ula_data_b      = b_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = id_q;
  assign rsp_result      = result_q;
  assign rsp_carry       = carry_q;
  assign rsp_err         = err_q;
  assign rsp_timeout     = timeout_q;

endmodule

// File: tb/tb_ula_rr_scheduler.sv
// Directed bench for ula_rr_scheduler with a small behavioural ULA model.
module tb_ula_rr_scheduler;

  logic        clk, rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_op;
  logic [63:0] req_a, req_b;
  logic [4:0]  ula_op_selector;
  logic [15:0] ula_data_a, ula_data_b;
  logic        ula_data_valid;
  logic [31:0] ula_data_result;
  logic        ula_data_carryout;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_carry, rsp_err, rsp_timeout;
  logic        ula_dead;

  int n_vec  = 0;
  int n_miss = 0;

  ula_rr_scheduler #(.N_REQ(4), .TIMEOUT(15)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_a             (req_a),
    .req_b             (req_b),
    .ula_op_selector   (ula_op_selector),
    .ula_data_a        (ula_data_a),
    .ula_data_b        (ula_data_b),
    .ula_data_valid    (ula_data_valid),
    .ula_data_result   (ula_data_result),
    .ula_data_carryout (ula_data_carryout),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_id            (rsp_id),
    .rsp_result        (rsp_result),
    .rsp_carry         (rsp_carry),
    .rsp_err           (rsp_err),
    .rsp_timeout       (rsp_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ULA model: result one cycle after a nonzero op; silent when ula_dead.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ula_data_valid    <= 1'b0;
      ula_data_result   <= '0;
      ula_data_carryout <= 1'b0;
    end else if (!ula_dead && ula_op_selector != 5'd0) begin
      ula_data_valid <= 1'b1;
      case (ula_op_selector[3:0])
        4'd1: begin
          {ula_data_carryout, ula_data_result[15:0]} <= {1'b0, ula_data_a} + {1'b0, ula_data_b};
          ula_data_result[31:16] <= '0;
        end
        4'd3: begin
          ula_data_result   <= 32'(ula_data_a) * 32'(ula_data_b);
          ula_data_carryout <= 1'b0;
        end
        default: begin
          ula_data_result   <= {16'h0, ula_data_a ^ ula_data_b};
          ula_data_carryout <= 1'b0;
        end
      endcase
    end else begin
      ula_data_valid <= 1'b0;
    end
  end

  typedef struct {
    int          req;
    logic [3:0]  op;
    logic [15:0] a, b;
    logic        err;
    logic [31:0] res;
    logic        carry;
    int          lat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
    req_op[4*idx +: 4]  = op;
    req_a[16*idx +: 16] = a;
    req_b[16*idx +: 16] = b;
    req_valid[idx]      = 1'b1;
  endtask

  // From a negedge with the request granted: accept, drop it, wait for rsp_valid.
  task automatic accept_and_wait(input int idx, output int lat, output logic [4:0] op_seen);
    bit got;
    lat     = 0;
    op_seen = 5'd0;
    got     = 0;
    @(posedge clk);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      lat++;
      req_valid[idx] = 1'b0;
      if (ula_op_selector != 5'd0) op_seen = ula_op_selector;
      if (rsp_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("rsp_valid_wait", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [4:0]  op_seen;
    bit          got;

    tbl[0] = '{req: 0, op: 4'h1, a: 16'hFFFF, b: 16'h0001, err: 0, res: 32'h0,        carry: 1, lat: 3};
    tbl[1] = '{req: 2, op: 4'hF, a: 16'h1111, b: 16'h2222, err: 1, res: 32'h0,        carry: 0, lat: 1};
    tbl[2] = '{req: 1, op: 4'h1, a: 16'h1234, b: 16'h1111, err: 0, res: 32'h2345,     carry: 0, lat: 3};
    tbl[3] = '{req: 3, op: 4'h3, a: 16'h0100, b: 16'h0100, err: 0, res: 32'h00010000, carry: 0, lat: 3};
    tbl[4] = '{req: 2, op: 4'h0, a: 16'h0005, b: 16'h0006, err: 1, res: 32'h0,        carry: 0, lat: 1};
    tbl[5] = '{req: 0, op: 4'h9, a: 16'h0007, b: 16'h0008, err: 1, res: 32'h0,        carry: 0, lat: 1};
    tbl[6] = '{req: 3, op: 4'h8, a: 16'hF0F0, b: 16'h0FF0, err: 0, res: 32'h0000FF00, carry: 0, lat: 3};
    tbl[7] = '{req: 1, op: 4'h5, a: 16'hAAAA, b: 16'h5555, err: 0, res: 32'h0000FFFF, carry: 0, lat: 3};

    rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; ula_dead = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Reset state.
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_ula_op", ula_op_selector, 0);
    chk("reset_rsp_fields", {rsp_id, rsp_result, rsp_carry, rsp_err, rsp_timeout}, 0);
    chk("reset_ula_ab", {ula_data_a, ula_data_b}, 0);
    rst = 1'b0;
    #1;
    chk("idle_no_ready", req_ready, 0);

    // Single-request vectors.
    foreach (tbl[i]) begin
      @(negedge clk);
      set_req(tbl[i].req, tbl[i].op, tbl[i].a, tbl[i].b);
      #1;
      chk($sformatf("v%0d grant", i), req_ready, 64'(4'b1 << tbl[i].req));
      accept_and_wait(tbl[i].req, lat, op_seen);
      chk($sformatf("v%0d latency", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("v%0d id", i), rsp_id, 64'(tbl[i].req));
      chk($sformatf("v%0d result", i), rsp_result, tbl[i].res);
      chk($sformatf("v%0d carry", i), rsp_carry, tbl[i].carry);
      chk($sformatf("v%0d err", i), rsp_err, tbl[i].err);
      chk($sformatf("v%0d timeout", i), rsp_timeout, 0);
      chk($sformatf("v%0d ula_op", i), op_seen, tbl[i].err ? 5'd0 : {1'b0, tbl[i].op});
    end

    // Round robin from reset: all four pending, expect 0,1,2,3,0.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 4'h3, 16'd3, 16'd5);
    for (int k = 0; k < 5; k++) begin
      got = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        #1;
        if (rsp_valid) begin
          got = 1;
          break;
        end
      end
      if (k == 4) req_valid = '0;
      chk($sformatf("rr%0d seen", k), got, 1);
      chk($sformatf("rr%0d id", k), rsp_id, 64'(k % 4));
      chk($sformatf("rr%0d result", k), rsp_result, 32'd15);
    end

    // Timeout: ULA never answers.
    @(negedge clk);
    @(negedge clk);
    ula_dead = 1'b1;
    set_req(0, 4'h1, 16'd1, 16'd1);
    #1;
    chk("to grant", req_ready, 4'b0001);
    accept_and_wait(0, lat, op_seen);
    chk("to latency", 64'(lat), 64'd17);
    chk("to flags", {rsp_timeout, rsp_err}, 2'b10);
    chk("to result", {rsp_result, rsp_carry}, 0);
    ula_dead = 1'b0;

    // Backpressure: response held for 10 cycles, no grant meanwhile.
    @(negedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 4'h1, 16'd5, 16'd3);
    accept_and_wait(1, lat, op_seen);
    set_req(2, 4'h1, 16'd1, 16'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d hold", c), {rsp_valid, rsp_id, rsp_result, rsp_carry, req_ready},
          {1'b1, 2'd1, 32'd8, 1'b0, 4'b0000});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("bp released", {rsp_valid, req_ready}, {1'b0, 4'b0100});
    accept_and_wait(2, lat, op_seen);
    chk("bp next", {rsp_id, rsp_result}, {2'd2, 32'd2});

    // Reset mid-WAIT: outputs clear at once; req 0 wins next.
    @(negedge clk);
    @(negedge clk);
    ula_dead = 1'b1;
    set_req(3, 4'h1, 16'hABCD, 16'h1234);
    accept_and_wait(3, lat, op_seen);
    chk("rw no early rsp", 64'(lat), 64'd17);
    @(negedge clk);
    @(negedge clk);
    set_req(3, 4'h1, 16'hABCD, 16'h1234);
    @(posedge clk);
    req_valid = 4'b0000;
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rw outputs", {rsp_valid, ula_op_selector, ula_data_a, ula_data_b, rsp_timeout, req_ready},
        0);
    set_req(0, 4'h3, 16'd2, 16'd4);
    set_req(3, 4'h3, 16'd9, 16'd9);
    #1;
    chk("rw ready in reset", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    ula_dead = 1'b0;
    #1;
    chk("rw grant", req_ready, 4'b0001);
    accept_and_wait(0, lat, op_seen);
    req_valid = '0;
    chk("rw rsp", {rsp_id, rsp_result, rsp_timeout}, {2'd0, 32'd8, 1'b0});

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
